// File: rtl/program_loader.sv
`default_nettype none
// program_loader: assembles a UART byte stream into big-endian instruction words and writes them
// from address 0, holding the CPU in reset until the all-zero halt word is stored. Optional: PROGRAM_LOADER_TIMEOUT_EN.
module program_loader #(
    parameter int NB_ADDR   = 10,
    parameter int NB_DATA   = 32,
    parameter int NB_BYTE   = 8,
    parameter int ROM_DEPTH = 1024
`ifdef PROGRAM_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_byte_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_cpu_reset,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [NB_ADDR:0]   o_word_count
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_IDX = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [NB_IDX-1:0]  LAST_IDX  = NB_IDX'(BYTES_PER_WORD - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(ROM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [NB_IDX-1:0]    byte_idx, byte_idx_next;
    logic [NB_ADDR-1:0]   addr_cnt, addr_cnt_next;
    logic [NB_DATA-1:0]   asm_word, asm_next, word_full;
    logic                 wr_en_next;
    logic [NB_ADDR-1:0]   wr_addr_next;
    logic [NB_DATA-1:0]   wr_data_next;
    logic [NB_ADDR:0]     word_count_next;

`ifdef PROGRAM_LOADER_TIMEOUT_EN
    localparam int NB_TO = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(TIMEOUT_CYCLES - 1);
    logic [NB_TO-1:0] to_cnt, to_next;
`endif

    always_comb begin
        state_next      = state;
        byte_idx_next   = byte_idx;
        addr_cnt_next   = addr_cnt;
        asm_next        = asm_word;
        wr_en_next      = 1'b0;
        wr_addr_next    = o_wr_addr;
        wr_data_next    = o_wr_data;
        word_count_next = o_word_count;
        // Shift form keeps the expression legal even when a word is a single byte.
        word_full       = (asm_word << NB_BYTE) | NB_DATA'(i_byte);
`ifdef PROGRAM_LOADER_TIMEOUT_EN
        to_next         = to_cnt;
`endif
        case (state)
            RECV: begin
                if (i_byte_valid) begin
                    asm_next = word_full;
                    if (byte_idx == LAST_IDX) begin
                        byte_idx_next   = '0;
                        wr_en_next      = 1'b1;
                        wr_addr_next    = addr_cnt;
                        wr_data_next    = word_full;
                        addr_cnt_next   = addr_cnt + 1'b1;
                        word_count_next = o_word_count + 1'b1;
                        if (word_full == '0) begin
                            state_next = DONE;
                        end else if (addr_cnt == LAST_ADDR) begin
                            state_next = ERROR;
                        end
                    end else begin
                        byte_idx_next = byte_idx + 1'b1;
                    end
                end
`ifdef PROGRAM_LOADER_TIMEOUT_EN
                if (i_byte_valid) begin
                    to_next = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_next = ERROR;
                end else begin
                    to_next = to_cnt + 1'b1;
                end
`endif
            end
            default: begin
                if (i_start) begin
                    state_next      = RECV;
                    byte_idx_next   = '0;
                    addr_cnt_next   = '0;
                    word_count_next = '0;
                    asm_next        = '0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
                    to_next         = '0;
`endif
                end
            end
        endcase
    end

    // Status flags are decoded from the next state so every output is a plain flop.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            byte_idx     <= '0;
            addr_cnt     <= '0;
            asm_word     <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_word_count <= '0;
            o_cpu_reset  <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            state        <= state_next;
            byte_idx     <= byte_idx_next;
            addr_cnt     <= addr_cnt_next;
            asm_word     <= asm_next;
            o_wr_en      <= wr_en_next;
            o_wr_addr    <= wr_addr_next;
            o_wr_data    <= wr_data_next;
            o_word_count <= word_count_next;
            o_cpu_reset  <= (state_next != DONE);
            o_busy       <= (state_next == RECV);
            o_done       <= (state_next == DONE);
            o_error      <= (state_next == ERROR);
`ifdef PROGRAM_LOADER_TIMEOUT_EN
            to_cnt       <= to_next;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// tb_program_loader: random and directed loads checked every cycle against a word-level model.
`timescale 1ns/1ps
module tb_program_loader;

    localparam int NB_ADDR   = 10;
    localparam int NB_DATA   = 32;
    localparam int NB_BYTE   = 8;
    localparam int ROM_DEPTH = 4;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 50;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               valid = 1'b0;
    logic [NB_BYTE-1:0] bval = '0;
    logic               wr_en;
    logic [NB_ADDR-1:0] wr_addr;
    logic [NB_DATA-1:0] wr_data;
    logic               cpu_reset, busy, done, error;
    logic [NB_ADDR:0]   word_count;

    always #5 clk = ~clk;

    program_loader #(
        .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .ROM_DEPTH(ROM_DEPTH)
`ifdef PROGRAM_LOADER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_byte_valid(valid), .i_byte(bval),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_cpu_reset(cpu_reset),
        .o_busy(busy), .o_done(done), .o_error(error), .o_word_count(word_count)
    );

    // Model: 0 idle, 1 loading, 2 done, 3 error.
    int               mode;
    logic [7:0]       mq[$];
    int               m_count, m_idle, m_addr;
    bit               m_wr;
    logic [31:0]      m_data;
    int               tests = 0;
    int               fails = 0;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t wlog[$];

    logic [7:0] prog [12] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h07,
                              8'h00, 8'h00, 8'h00, 8'h00};

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mode = 0; mq.delete(); m_count = 0; m_idle = 0; m_wr = 0; m_addr = 0; m_data = '0;
    endfunction

    function automatic void model_step(bit s, bit v, logic [7:0] b);
        m_wr = 0;
        if (mode != 1) begin
            if (s) begin
                mode = 1; mq.delete(); m_count = 0; m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            mq.push_back(b);
            if (mq.size() == 4) begin
                m_data = {mq[0], mq[1], mq[2], mq[3]};
                mq.delete();
                m_wr = 1; m_addr = m_count; m_count++;
                if (m_data == 0) mode = 2;
                else if (m_count == ROM_DEPTH) mode = 3;
            end
        end
`ifdef PROGRAM_LOADER_TIMEOUT_EN
        else begin
            m_idle++;
            if (m_idle == TIMEOUT_CYCLES) begin
                mode = 3; mq.delete();
            end
        end
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("wr_en", wr_en, m_wr);
            if (m_wr && wr_en) begin
                chk("wr_addr", wr_addr, m_addr);
                chk("wr_data", wr_data, m_data);
            end
            if (wr_en) wlog.push_back('{int'(wr_addr), wr_data});
            chk("busy", busy, mode == 1);
            chk("done", done, mode == 2);
            chk("error", error, mode == 3);
            chk("cpu_reset", cpu_reset, mode != 2);
            chk("word_count", word_count, m_count);
        end
    end

    task automatic tick(input bit s, input bit v, input logic [7:0] b);
        @(negedge clk);
        start = s; valid = v; bval = b;
        @(posedge clk);
        model_step(s, v, b);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 0; valid = 0;
        #2 rst_n = 0;
        #1 check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic send_prog(input int gapmax, input bit pin_latency);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, gapmax)) tick(0, 0, 8'($urandom));
            tick(0, 1, prog[i]);
            if (pin_latency && i == 3) #1 chk("latency_first_write", wr_en, 1);
        end
        repeat (2) tick(0, 0, 8'h00);
    endtask

    task automatic check_prog_log(string tag);
        chk({tag, "_nwrites"}, wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk({tag, "_w0"}, {wlog[0].addr, wlog[0].data}, {32'd0, 32'h8C010004});
            chk({tag, "_w1"}, {wlog[1].addr, wlog[1].data}, {32'd1, 32'h20020007});
            chk({tag, "_w2"}, {wlog[2].addr, wlog[2].data}, {32'd2, 32'h00000000});
        end
        #1;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_cpu_reset"}, cpu_reset, 0);
        chk({tag, "_count"}, word_count, 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1;

        // Bytes before any start are dropped.
        wlog.delete();
        repeat (6) tick(0, 1, 8'($urandom));
        chk("pre_start_writes", wlog.size(), 0);

        // Back-to-back load.
        tick(1, 0, 8'h00);
        send_prog(0, 1);
        check_prog_log("b2b");

        // Bytes while DONE are dropped.
        wlog.delete();
        repeat (8) tick(0, 1, 8'h5A);
        chk("done_ignore_writes", wlog.size(), 0);
        #1 chk("done_ignore_count", word_count, 3);

        // Gapped load, restarted from DONE with a simultaneous byte.
        wlog.delete();
        tick(1, 1, 8'hFF);
        send_prog(5, 0);
        check_prog_log("gapped");

        // Second start mid-word is ignored.
        wlog.delete();
        tick(1, 0, 8'h00);
        tick(0, 1, prog[0]);
        tick(0, 1, prog[1]);
        tick(1, 0, 8'h00);
        tick(1, 1, prog[2]);
        for (int i = 3; i < 12; i++) tick(0, 1, prog[i]);
        repeat (2) tick(0, 0, 8'h00);
        check_prog_log("restart_ignored");

        // Reset after 2 bytes of the second word, then reload from address 0.
        tick(1, 0, 8'h00);
        for (int i = 0; i < 6; i++) tick(0, 1, prog[i]);
        do_reset();
        wlog.delete();
        tick(1, 0, 8'h00);
        send_prog(1, 0);
        check_prog_log("after_reset");

        // Overflow: ROM_DEPTH non-zero words.
        wlog.delete();
        tick(1, 0, 8'h00);
        for (int i = 0; i < 4 * ROM_DEPTH; i++) tick(0, 1, 8'(8'h11 + i));
        repeat (3) tick(0, 1, 8'h00);
        #1;
        chk("ovf_error", error, 1);
        chk("ovf_cpu_reset", cpu_reset, 1);
        chk("ovf_done", done, 0);
        chk("ovf_nwrites", wlog.size(), ROM_DEPTH);
        if (wlog.size() == ROM_DEPTH) chk("ovf_last_addr", wlog[ROM_DEPTH-1].addr, ROM_DEPTH - 1);

`ifdef PROGRAM_LOADER_TIMEOUT_EN
        wlog.delete();
        tick(1, 0, 8'h00);
        tick(0, 1, 8'hAB);
        tick(0, 1, 8'hCD);
        repeat (TIMEOUT_CYCLES - 1) tick(0, 0, 8'h00);
        #1 chk("to_not_yet", error, 0);
        tick(0, 0, 8'h00);
        #1 chk("to_error", error, 1);
        chk("to_nwrites", wlog.size(), 0);
`endif

        // Randomised loads with gaps, stray starts and occasional resets.
        for (int it = 0; it < 40; it++) begin
            tick(1, 1'($urandom_range(0, 1)), 8'($urandom));
            for (int w = 0, nw = $urandom_range(1, 5); w < nw; w++) begin
                bit zero = ($urandom_range(0, 3) == 0);
                for (int k = 0; k < 4; k++) begin
                    repeat ($urandom_range(0, 3)) tick($urandom_range(0, 15) == 0, 0, 8'($urandom));
                    tick($urandom_range(0, 15) == 0, 1, zero ? 8'h00 : 8'($urandom));
                end
            end
            if ($urandom_range(0, 7) == 0) do_reset();
            repeat ($urandom_range(1, 4)) tick(0, $urandom_range(0, 1), 8'($urandom));
        end

        repeat (2) tick(0, 0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
